// File: rtl/tt_mux_pkg.sv
// Shared constants and types for the multi-project mux: select sizing,
// pin-enable patterns and the per-slot output bundle.
package tt_mux_pkg;

  localparam int SEL_W       = 3;
  localparam int NUM_DESIGNS = 4;

  localparam logic [7:0] OE_NONE  = 8'h00;
  localparam logic [7:0] OE_ALL   = 8'hFF;
  localparam logic [7:0] OE_UPPER = 8'hF0;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
  } slot_io_t;

  localparam slot_io_t SLOT_IO_IDLE = '{uo: 8'h00, uio_out: 8'h00, uio_oe: OE_NONE};

  // A slot runs only while it is the selected one and the global enable is up.
  function automatic logic slot_run(input logic [SEL_W-1:0] sel,
                                    input logic [SEL_W-1:0] idx,
                                    input logic             ena);
    return ena && (sel == idx);
  endfunction

endpackage

// File: rtl/tt_mux_if.sv
// Shared user pins plus the asynchronous control pins of the mux.
interface tt_mux_if;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  // Driver side (pad ring / test harness).
  modport master (
    output ui_in, uio_in, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    input  uo_out, uio_out, uio_oe
  );

  // Mux side.
  modport slave (
    input  ui_in, uio_in, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_mux_ctrl.sv
// Control front end: synchronizes the three async control pins, detects the
// rising edge of the increment strobe and maintains the design select counter.
module tt_mux_ctrl
  import tt_mux_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_sel_rst_n,
  input  logic             ctrl_sel_inc,
  input  logic             ctrl_ena,
  output logic [SEL_W-1:0] sel,
  output logic             ena_s
);

  logic             sel_rst_meta_r;
  logic             sel_rst_sync_r;
  logic             inc_meta_r;
  logic             inc_sync_r;
  logic             inc_prev_r;
  logic             ena_meta_r;
  logic             ena_sync_r;
  logic [SEL_W-1:0] sel_r;
  logic             inc_rise_s;

  // Two-flop synchronizers; the clear idles high, strobe and enable idle low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_rst_meta_r <= 1'b1;
      sel_rst_sync_r <= 1'b1;
      inc_meta_r     <= 1'b0;
      inc_sync_r     <= 1'b0;
      inc_prev_r     <= 1'b0;
      ena_meta_r     <= 1'b0;
      ena_sync_r     <= 1'b0;
    end else begin
      sel_rst_meta_r <= ctrl_sel_rst_n;
      sel_rst_sync_r <= sel_rst_meta_r;
      inc_meta_r     <= ctrl_sel_inc;
      inc_sync_r     <= inc_meta_r;
      inc_prev_r     <= inc_sync_r;
      ena_meta_r     <= ctrl_ena;
      ena_sync_r     <= ena_meta_r;
    end
  end

  // Edge detect on the synced strobe; inc_prev always advances, so an edge
  // that coincides with a clear is dropped rather than held for later.
  always_comb begin
    inc_rise_s = inc_sync_r & ~inc_prev_r;
  end

  // Select counter: level clear dominates, otherwise one step per strobe edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_r <= SEL_W'(0);
    end else if (!sel_rst_sync_r) begin
      sel_r <= SEL_W'(0);
    end else if (inc_rise_s) begin
      sel_r <= sel_r + SEL_W'(1);
    end else begin
      sel_r <= sel_r;
    end
  end

  assign sel   = sel_r;
  assign ena_s = ena_sync_r;

endmodule

// File: rtl/tt_mux_top.sv
// Multi-project mux top: hosts four tiny user designs, runs only the selected
// one (the rest sit in reset) and routes its outputs to the shared pins.
module tt_mux_top
  import tt_mux_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  tt_mux_if.slave  pins
);

  logic [SEL_W-1:0] sel_s;
  logic             ena_s;
  logic [3:0]       run_s;
  logic [7:0]       cnt_r;
  logic [7:0]       sum_r;
  slot_io_t         slot_io_s [NUM_DESIGNS];
  slot_io_t         out_s;

  tt_mux_ctrl u_ctrl (
    .clk            (clk),
    .reset_n        (reset_n),
    .ctrl_sel_rst_n (pins.ctrl_sel_rst_n),
    .ctrl_sel_inc   (pins.ctrl_sel_inc),
    .ctrl_ena       (pins.ctrl_ena),
    .sel            (sel_s),
    .ena_s          (ena_s)
  );

  // Per-slot run flags; a slot that is not running is held in reset.
  always_comb begin
    run_s[0] = slot_run(sel_s, SEL_W'(0), ena_s);
    run_s[1] = slot_run(sel_s, SEL_W'(1), ena_s);
    run_s[2] = slot_run(sel_s, SEL_W'(2), ena_s);
    run_s[3] = slot_run(sel_s, SEL_W'(3), ena_s);
  end

  // Slot 1 state: free-running 8-bit counter, restarts at zero on selection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 8'h00;
    end else if (!run_s[1]) begin
      cnt_r <= 8'h00;
    end else begin
      cnt_r <= cnt_r + 8'h01;
    end
  end

  // Slot 2 state: registered sum of the two input buses, modulo 256.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_r <= 8'h00;
    end else if (!run_s[2]) begin
      sum_r <= 8'h00;
    end else begin
      sum_r <= pins.ui_in + pins.uio_in;
    end
  end

  // Slot output bundles; slot 3 drives all of uio_out but enables only [7:4].
  always_comb begin
    slot_io_s[0] = '{uo: pins.ui_in,                uio_out: 8'h00,       uio_oe: OE_NONE};
    slot_io_s[1] = '{uo: cnt_r,                     uio_out: ~cnt_r,      uio_oe: OE_ALL};
    slot_io_s[2] = '{uo: sum_r,                     uio_out: 8'h00,       uio_oe: OE_NONE};
    slot_io_s[3] = '{uo: pins.ui_in ^ pins.uio_in,  uio_out: pins.ui_in,  uio_oe: OE_UPPER};
  end

  // Output mux; disabled or empty select values park every pin at zero.
  always_comb begin
    out_s = SLOT_IO_IDLE;
    if (!ena_s) begin
      out_s = SLOT_IO_IDLE;
    end else begin
      case (sel_s)
        SEL_W'(0): out_s = slot_io_s[0];
        SEL_W'(1): out_s = slot_io_s[1];
        SEL_W'(2): out_s = slot_io_s[2];
        SEL_W'(3): out_s = slot_io_s[3];
        default:   out_s = SLOT_IO_IDLE;
      endcase
    end
  end

  assign pins.uo_out  = out_s.uo;
  assign pins.uio_out = out_s.uio_out;
  assign pins.uio_oe  = out_s.uio_oe;

endmodule

// File: tb/tb_tt_mux_top.sv
// Directed bench for tt_mux_top: select sequencing, each slot function,
// enable gating, empty slots and asynchronous reset.
module tb_tt_mux_top;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  tt_mux_if pins ();

  tt_mux_top dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pins    (pins)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check8(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  task automatic check_io(input string tag, input logic [7:0] uo,
                          input logic [7:0] uio, input logic [7:0] oe);
    check8({tag, ".uo"},  pins.uo_out,  uo);
    check8({tag, ".uio"}, pins.uio_out, uio);
    check8({tag, ".oe"},  pins.uio_oe,  oe);
  endtask

  // Advance n rising edges and settle 2 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_inc();
    pins.ctrl_sel_inc = 1'b1;
    step(4);
    pins.ctrl_sel_inc = 1'b0;
    step(4);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n             = 1'b0;
    pins.ui_in          = 8'h00;
    pins.uio_in         = 8'h00;
    pins.ctrl_sel_rst_n = 1'b1;
    pins.ctrl_sel_inc   = 1'b0;
    pins.ctrl_ena       = 1'b0;

    #3;
    check_io("reset", 8'h00, 8'h00, 8'h00);
    #19 reset_n = 1'b1;
    step(2);

    // Passthrough on slot 0; enable takes two edges to arrive.
    pins.ui_in    = 8'hA5;
    pins.ctrl_ena = 1'b1;
    step(1);
    check8("ena_sync1", pins.uo_out, 8'h00);
    step(1);
    check_io("pass", 8'hA5, 8'h00, 8'h00);

    // Slot 2: registered adder.
    pulse_inc();
    pulse_inc();
    pins.ui_in  = 8'h10;
    pins.uio_in = 8'h20;
    step(1);
    check_io("add", 8'h30, 8'h00, 8'h00);
    pins.ui_in = 8'hF0;
    step(1);
    check8("add_wrap", pins.uo_out, 8'h10);

    // Held strobe: one increment, landing on the third edge.
    pins.ctrl_sel_inc = 1'b1;
    step(2);
    check8("inc_edge2", pins.uo_out, 8'h10);
    step(1);
    check_io("inc_edge3", 8'hD0, 8'hF0, 8'hF0);
    step(17);
    check8("inc_held", pins.uo_out, 8'hD0);
    pins.ui_in  = 8'h0F;
    pins.uio_in = 8'h3C;
    #1;
    check_io("loop", 8'h33, 8'h0F, 8'hF0);
    pins.ctrl_sel_inc = 1'b0;
    step(4);

    // Select clear lands on the third edge.
    pins.ctrl_sel_rst_n = 1'b0;
    step(2);
    check8("clr_edge2", pins.uo_out, 8'h33);
    step(1);
    check_io("clr_edge3", 8'h0F, 8'h00, 8'h00);
    pins.ctrl_sel_rst_n = 1'b1;
    step(3);

    // Strobe edge coinciding with clear is consumed, not replayed.
    pulse_inc();
    check8("sel1_oe", pins.uio_oe, 8'hFF);
    pins.ctrl_sel_inc   = 1'b1;
    pins.ctrl_sel_rst_n = 1'b0;
    step(5);
    check8("both_clr", pins.uo_out, 8'h0F);
    pins.ctrl_sel_rst_n = 1'b1;
    step(4);
    check8("no_replay", pins.uo_out, 8'h0F);
    pins.ctrl_sel_inc = 1'b0;
    step(4);

    // Slot 1 counter.
    pins.ctrl_sel_inc = 1'b1;
    step(3);
    check_io("cnt0", 8'h00, 8'hFF, 8'hFF);
    step(1);
    check_io("cnt1", 8'h01, 8'hFE, 8'hFF);
    step(1);
    check8("cnt2", pins.uo_out, 8'h02);
    pins.ctrl_sel_inc = 1'b0;
    step(256);
    check8("cnt_wrap", pins.uo_out, 8'h02);
    step(62);
    check8("cnt40", pins.uo_out, 8'h40);

    // Enable drop and recovery.
    pins.ctrl_ena = 1'b0;
    step(1);
    check8("ena_drop1", pins.uo_out, 8'h41);
    step(1);
    check_io("ena_off", 8'h00, 8'h00, 8'h00);
    pins.ctrl_ena = 1'b1;
    step(1);
    check8("ena_on1", pins.uo_out, 8'h00);
    step(1);
    check_io("cnt_restart", 8'h00, 8'hFF, 8'hFF);
    step(1);
    check8("cnt_restart1", pins.uo_out, 8'h01);

    // Empty slot 7, then wrap back to slot 0.
    pins.ui_in  = 8'h5A;
    pins.uio_in = 8'hC3;
    for (int i = 0; i < 6; i++) pulse_inc();
    check_io("empty7", 8'h00, 8'h00, 8'h00);
    pulse_inc();
    check_io("sel_wrap", 8'h5A, 8'h00, 8'h00);

    // Asynchronous reset mid-cycle from slot 3.
    for (int i = 0; i < 3; i++) pulse_inc();
    check_io("loop2", 8'h99, 8'h5A, 8'hF0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_io("async_rst", 8'h00, 8'h00, 8'h00);
    #4 reset_n = 1'b1;
    step(1);
    check8("rst_ena1", pins.uo_out, 8'h00);
    step(1);
    check_io("rst_sel0", 8'h5A, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
